lcd_refresh_scheduler: RTL and testbench

- Sequences the LCD instruction-transmit FSM after power-on initialisation completes.
- Periodically writes a 32-character frame (2 lines × 16) from an external character memory to the HD44780-style panel:
  - Set DDRAM address 0x00, then 16 data writes.
  - Set DDRAM address 0x40, then 16 data writes.
  - Wait the refresh interval, then repeat.
- Top level routes instruction/enable from this block to the transmit FSM whenever init_done=1, and from the init FSM otherwise.

---
 rtl/lcd_pkg.sv | 41 ++++
 rtl/lcd_refresh_scheduler_if.sv | 11 +
 rtl/lcd_interval_timer.sv | 37 +++
 rtl/lcd_refresh_scheduler.sv | 165 ++++++++++++++++
 tb/tb_lcd_refresh_scheduler.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared constants for the LCD refresh scheduler: FSM state encoding, HD44780 opcodes,
// frame geometry and interval-timer width.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_CLEAR_WAIT,
    ST_SET_ADDR,
    ST_FETCH,
    ST_LATCH,
    ST_WRITE,
    ST_WAIT_REFRESH
  } state_t;

  localparam int INSTR_W      = 10;
  localparam int TMR_W        = 26;
  localparam int LCD_LINE_LEN = 16;
  localparam int LCD_CHARS    = 32;
  localparam int IDX_W        = $clog2(LCD_CHARS);

  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_DDRAM_L1 = 8'h80;
  localparam logic [7:0] CMD_DDRAM_L2 = 8'hC0;

  localparam logic [1:0] RSRW_CMD  = 2'b00;
  localparam logic [1:0] RSRW_DATA = 2'b10;

  localparam logic [IDX_W-1:0] IDX_L1_END   = IDX_W'(LCD_LINE_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_L2_START = IDX_W'(LCD_LINE_LEN);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(LCD_CHARS - 1);

  function automatic logic [INSTR_W-1:0] lcd_cmd(input logic [7:0] op);
    return {RSRW_CMD, op};
  endfunction

  function automatic logic [INSTR_W-1:0] lcd_data(input logic [7:0] ch);
    return {RSRW_DATA, ch};
  endfunction

endpackage

// File: rtl/lcd_refresh_scheduler_if.sv
// Instruction handshake between the refresh scheduler (master) and the LCD transmit FSM (slave).
interface lcd_refresh_scheduler_if;
  import lcd_pkg::*;

  logic               instr_fsm_enable;
  logic [INSTR_W-1:0] instruction;
  logic               instr_fsm_done;

  modport master (output instr_fsm_enable, output instruction, input  instr_fsm_done);
  modport slave  (input  instr_fsm_enable, input  instruction, output instr_fsm_done);
endinterface

// File: rtl/lcd_interval_timer.sv
// Loadable down-counter; o_tc is high for the one cycle the loaded count has run out.
module lcd_interval_timer
  import lcd_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clear,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;
  logic         r_active;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (i_clear) begin
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (i_load) begin
      r_cnt    <= i_load_val;
      r_active <= 1'b1;
    end else if (r_active) begin
      if (r_cnt == '0) r_active <= 1'b0;
      else             r_cnt    <= r_cnt - 1'b1;
    end
  end

  // Loading N-1 makes the terminal count land N cycles after the load edge
  assign o_tc = r_active && (r_cnt == '0);

endmodule

// File: rtl/lcd_refresh_scheduler.sv
// Periodic 2x16 frame writer for an HD44780-style panel, run once power-on init is done.
// Optional macro LCD_CLEAR_BEFORE_REFRESH_EN: prefix every frame with Clear Display + wait.
module lcd_refresh_scheduler
  import lcd_pkg::*;
#(
  parameter int REFRESH_CYCLES = 50_000_000
`ifdef LCD_CLEAR_BEFORE_REFRESH_EN
  , parameter int CLEAR_WAIT_CYCLES = 82_000
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_init_done,
  input  logic                    i_refresh_req,
  input  logic [7:0]              i_char_data,
  output logic [IDX_W-1:0]        o_char_addr,
  output logic                    o_busy,
  output logic                    o_frame_done,
  lcd_refresh_scheduler_if.master bus
);

  localparam logic [TMR_W-1:0] REFRESH_VAL = TMR_W'(REFRESH_CYCLES - 1);

`ifdef LCD_CLEAR_BEFORE_REFRESH_EN
  localparam logic [TMR_W-1:0]   CLEAR_VAL   = TMR_W'(CLEAR_WAIT_CYCLES - 1);
  localparam state_t             START_ST    = ST_CLEAR;
  localparam logic [INSTR_W-1:0] START_INSTR = {RSRW_CMD, CMD_CLEAR};
`else
  localparam state_t             START_ST    = ST_SET_ADDR;
  localparam logic [INSTR_W-1:0] START_INSTR = {RSRW_CMD, CMD_DDRAM_L1};
`endif

  state_t             r_state;
  logic               r_enable;
  logic [INSTR_W-1:0] r_instr;
  logic [IDX_W-1:0]   r_char_addr;
  logic [IDX_W-1:0]   r_index;
  logic               r_busy;
  logic               r_frame_done;

  logic               w_done;
  logic               w_load_refresh;
  logic               w_tmr_clear;
  logic               w_tmr_load;
  logic [TMR_W-1:0]   w_tmr_val;
  logic               w_tmr_tc;
  logic               w_start;

  // done is only meaningful while a request is outstanding
  assign w_done         = r_enable && bus.instr_fsm_done;
  assign w_load_refresh = i_init_done && (r_state == ST_WRITE) && w_done && (r_index == IDX_LAST);
  assign w_tmr_clear    = !i_init_done || ((r_state == ST_WAIT_REFRESH) && i_refresh_req);
  assign w_start        = (r_state == ST_IDLE) || w_tmr_tc || i_refresh_req;

`ifdef LCD_CLEAR_BEFORE_REFRESH_EN
  logic w_load_clear;
  assign w_load_clear = i_init_done && (r_state == ST_CLEAR) && w_done;
  assign w_tmr_load   = w_load_refresh || w_load_clear;
  assign w_tmr_val    = w_load_clear ? CLEAR_VAL : REFRESH_VAL;
`else
  assign w_tmr_load   = w_load_refresh;
  assign w_tmr_val    = REFRESH_VAL;
`endif

  lcd_interval_timer #(.W(TMR_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (w_tmr_clear),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_tc       (w_tmr_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_enable     <= 1'b0;
      r_instr      <= '0;
      r_char_addr  <= '0;
      r_index      <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else if (!i_init_done) begin
      // Losing init abandons whatever is in flight; the next frame starts from scratch
      r_state      <= ST_IDLE;
      r_enable     <= 1'b0;
      r_instr      <= '0;
      r_char_addr  <= '0;
      r_index      <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_WAIT_REFRESH: begin
          if (w_start) begin
            r_state  <= START_ST;
            r_instr  <= START_INSTR;
            r_enable <= 1'b1;
            r_busy   <= 1'b1;
            r_index  <= '0;
          end
        end
`ifdef LCD_CLEAR_BEFORE_REFRESH_EN
        ST_CLEAR: begin
          if (w_done) begin
            r_enable <= 1'b0;
            r_state  <= ST_CLEAR_WAIT;
          end
        end
        ST_CLEAR_WAIT: begin
          if (w_tmr_tc) begin
            r_state  <= ST_SET_ADDR;
            r_instr  <= lcd_cmd(CMD_DDRAM_L1);
            r_enable <= 1'b1;
          end
        end
`endif
        ST_SET_ADDR: begin
          // Entered with enable low only from the line-1 end, which gives the low gap
          if (!r_enable) begin
            r_instr  <= lcd_cmd((r_index == IDX_L2_START) ? CMD_DDRAM_L2 : CMD_DDRAM_L1);
            r_enable <= 1'b1;
          end else if (w_done) begin
            r_enable    <= 1'b0;
            r_char_addr <= r_index;
            r_state     <= ST_FETCH;
          end
        end
        ST_FETCH: r_state <= ST_LATCH;
        ST_LATCH: begin
          r_instr  <= lcd_data(i_char_data);
          r_enable <= 1'b1;
          r_state  <= ST_WRITE;
        end
        ST_WRITE: begin
          if (w_done) begin
            r_enable <= 1'b0;
            if (r_index == IDX_LAST) begin
              r_index      <= '0;
              r_busy       <= 1'b0;
              r_frame_done <= 1'b1;
              r_state      <= ST_WAIT_REFRESH;
            end else if (r_index == IDX_L1_END) begin
              r_index <= r_index + 1'b1;
              r_state <= ST_SET_ADDR;
            end else begin
              r_index     <= r_index + 1'b1;
              r_char_addr <= r_index + 1'b1;
              r_state     <= ST_FETCH;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.instr_fsm_enable = r_enable;
  assign bus.instruction      = r_instr;
  assign o_char_addr          = r_char_addr;
  assign o_busy               = r_busy;
  assign o_frame_done         = r_frame_done;

endmodule

// File: tb/tb_lcd_refresh_scheduler.sv
// Bench for lcd_refresh_scheduler: instruction scoreboard, delayed-done transmit model,
// synchronous character memory, and hand sequences for timing and abort corner cases.
`timescale 1ns/1ps
module tb_lcd_refresh_scheduler;
  import lcd_pkg::*;

  localparam int REFRESH  = 100;
  localparam int DONE_LAT = 20;
`ifdef LCD_CLEAR_BEFORE_REFRESH_EN
  localparam int CLR_WAIT = 50;
  localparam logic [9:0] FIRST_INSTR = 10'h001;
`else
  localparam logic [9:0] FIRST_INSTR = 10'h080;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       init_done = 1'b0;
  logic       refresh_req = 1'b0;
  logic [7:0] char_data;
  logic [4:0] char_addr;
  logic       busy, frame_done;
  logic       model_done = 1'b0;
  logic       stray_done = 1'b0;

  lcd_refresh_scheduler_if bus();
  assign bus.instr_fsm_done = model_done | stray_done;

  always #5 clk = ~clk;

  lcd_refresh_scheduler #(
    .REFRESH_CYCLES(REFRESH)
`ifdef LCD_CLEAR_BEFORE_REFRESH_EN
    , .CLEAR_WAIT_CYCLES(CLR_WAIT)
`endif
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_init_done  (init_done),
    .i_refresh_req(refresh_req),
    .i_char_data  (char_data),
    .o_char_addr  (char_addr),
    .o_busy       (busy),
    .o_frame_done (frame_done),
    .bus          (bus)
  );

  typedef struct { logic [7:0] ch; logic [9:0] want; } vec_t;
  vec_t       tbl[LCD_CHARS];
  logic [7:0] mem[LCD_CHARS];
  logic [9:0] exp_q[$];
  int n_tests = 0, n_fail = 0, fd_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic push_frame();
`ifdef LCD_CLEAR_BEFORE_REFRESH_EN
    exp_q.push_back(10'h001);
`endif
    exp_q.push_back(10'h080);
    for (int i = 0; i < LCD_LINE_LEN; i++) exp_q.push_back(tbl[i].want);
    exp_q.push_back(10'h0C0);
    for (int i = LCD_LINE_LEN; i < LCD_CHARS; i++) exp_q.push_back(tbl[i].want);
  endtask

  task automatic wait_fd(input string nm);
    int n = 0;
    while (frame_done !== 1'b1 && n < 3000) begin tick(); n++; end
    chk(nm, frame_done, 1);
  endtask

  // synchronous character memory: data valid the cycle after the address
  always @(posedge clk) char_data <= mem[char_addr];

  // transmit-FSM model: one done pulse a fixed time after each enable rise
  int   dcnt = 0;
  logic m_prev = 1'b0;
  always @(negedge clk) begin
    m_prev <= bus.instr_fsm_enable;
    if (!bus.instr_fsm_enable) begin
      dcnt <= 0; model_done <= 1'b0;
    end else if (!m_prev) begin
      dcnt <= DONE_LAT; model_done <= 1'b0;
    end else if (dcnt == 1) begin
      dcnt <= 0; model_done <= 1'b1;
    end else begin
      if (dcnt > 0) dcnt <= dcnt - 1;
      model_done <= 1'b0;
    end
  end

  logic done_seen = 1'b0;
  always @(posedge clk) done_seen <= bus.instr_fsm_enable && bus.instr_fsm_done;

  logic       mon_en_prev = 1'b0, fd_prev = 1'b0, instr_moved = 1'b0;
  logic [9:0] instr_cap = '0;
  always @(negedge clk) begin
    if (done_seen) chk("en_low_after_done", bus.instr_fsm_enable, 0);
    if (bus.instr_fsm_enable && !mon_en_prev) begin
      chk("busy_at_enable", busy, 1);
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_instr: got %03h, none expected", bus.instruction);
      end else chk("instr_seq", bus.instruction, exp_q.pop_front());
      instr_cap   <= bus.instruction;
      instr_moved <= 1'b0;
    end else if (bus.instr_fsm_enable && bus.instruction !== instr_cap) instr_moved <= 1'b1;
    if (!bus.instr_fsm_enable && mon_en_prev) chk("instr_stable", instr_moved, 0);
    if (frame_done) begin fd_cnt++; chk("frame_done_pulse", fd_prev, 0); end
    mon_en_prev <= bus.instr_fsm_enable;
    fd_prev     <= frame_done;
  end

  initial begin
    int n;
    logic [9:0] saved_i;
    logic [4:0] saved_a;

    for (int i = 0; i < LCD_CHARS; i++) begin
      tbl[i].ch   = (i == 0) ? 8'h00 : (i == LCD_CHARS - 1) ? 8'hFF : 8'(i * 37 + 5);
      tbl[i].want = {2'b10, tbl[i].ch};
      mem[i]      = tbl[i].ch;
    end

    #1;
    chk("rst_enable", bus.instr_fsm_enable, 0);
    chk("rst_instr", bus.instruction, 0);
    chk("rst_char_addr", char_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    repeat (3) tick();
    reset = 1'b0;
    repeat (6) tick();
    chk("idle_enable", bus.instr_fsm_enable, 0);
    chk("idle_busy", busy, 0);

    // first frame: enable one cycle after init_done is sampled
    push_frame();
    init_done = 1'b1;
    tick();
    chk("first_enable", bus.instr_fsm_enable, 1);
    chk("first_instr", bus.instruction, FIRST_INSTR);
    chk("first_busy", busy, 1);
    wait_fd("frame1_done");

    // refresh interval with a stray done pulse while enable is low
    saved_i = bus.instruction;
    saved_a = char_addr;
    n = 0;
    tick(); n++;
    chk("frame1_count", fd_cnt, 1);
    chk("frame1_all_sent", exp_q.size(), 0);
    chk("busy_after_frame", busy, 0);
    push_frame();
    stray_done = 1'b1; tick(); n++; stray_done = 1'b0;
    tick(); n++;
    chk("stray_enable", bus.instr_fsm_enable, 0);
    chk("stray_busy", busy, 0);
    chk("stray_instr", bus.instruction, saved_i);
    chk("stray_char_addr", char_addr, saved_a);
    while (!bus.instr_fsm_enable && n < 400) begin tick(); n++; end
    chk("refresh_interval", n, REFRESH);

    // refresh_req during a frame must be ignored and not remembered
    repeat (60) tick();
    refresh_req = 1'b1; tick(); refresh_req = 1'b0;
    repeat (300) tick();
    refresh_req = 1'b1; tick(); refresh_req = 1'b0;
    wait_fd("frame2_done");
    tick();
    chk("frame2_count", fd_cnt, 2);
    chk("frame2_all_sent", exp_q.size(), 0);
    chk("no_queued_req", bus.instr_fsm_enable, 0);

    // refresh_req at counter 40 restarts immediately
    push_frame();
    repeat (39) tick();
    refresh_req = 1'b1; tick(); refresh_req = 1'b0;
    chk("req_restart_en", bus.instr_fsm_enable, 1);
    chk("req_restart_instr", bus.instruction, FIRST_INSTR);
`ifdef LCD_CLEAR_BEFORE_REFRESH_EN
    n = 0;
    while (bus.instr_fsm_enable && n < 100) begin tick(); n++; end
    n = 0;
    while (!bus.instr_fsm_enable && n < 200) begin tick(); n++; end
    chk("clear_wait_gap", n, CLR_WAIT);
    chk("after_clear_instr", bus.instruction, 10'h080);
`endif

    // init_done drop mid-write at index 7
    n = 0;
    while (!(bus.instr_fsm_enable && char_addr == 5'd7 && bus.instruction[9:8] == 2'b10) && n < 3000) begin
      tick(); n++;
    end
    chk("reach_idx7", bus.instr_fsm_enable && char_addr == 5'd7, 1);
    init_done = 1'b0;
    tick();
    chk("abort_enable", bus.instr_fsm_enable, 0);
    chk("abort_busy", busy, 0);
    exp_q.delete();
    repeat (5) tick();
    push_frame();
    init_done = 1'b1;
    tick();
    chk("rearm_enable", bus.instr_fsm_enable, 1);
    chk("rearm_instr", bus.instruction, FIRST_INSTR);
    wait_fd("frame4_done");
    tick();
    chk("frame4_count", fd_cnt, 3);
    chk("frame4_all_sent", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
